// File: rtl/mmio_uart_rx_pkg.sv
// Shared definitions for the MMIO UART receiver: register offsets, STATUS bit
// positions and RX FSM states. UART_RX_PARITY_EN adds the PARITY state (8E1).
package mmio_uart_rx_pkg;

  localparam logic [31:0] UART_RX_QUEUE_HEAD_OFFSET = 32'h0000_0100;
  localparam logic [31:0] UART_RX_QUEUE_TAIL_OFFSET = 32'h0000_0104;
  localparam logic [31:0] UART_RX_STATUS_OFFSET     = 32'h0000_0108;

  localparam int unsigned STATUS_OVERFLOW_BIT   = 0;
  localparam int unsigned STATUS_FRAME_ERR_BIT  = 1;
  localparam int unsigned STATUS_PARITY_ERR_BIT = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned fmax_mhz,
                                               input int unsigned baud);
    return (fmax_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/mmio_uart_rx_uart_rx.sv
// Serial deserialiser: two-flop synchroniser, edge detect and RX frame FSM.
// UART_RX_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx
  import mmio_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err_pulse,
  output logic       parity_err_pulse
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic          fall;
  logic          cnt_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // The sync chain resets to "idle high", which is not a real observation of the
  // line; edges are only honoured once a genuine high has passed through it.
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    settle_d  = {settle_q[0], 1'b1};
    armed_d   = armed_q | (settle_q[1] & sync2_q);
    fall      = armed_q & prev_q & ~sync2_q;
    cnt_full  = (cnt_q == FULL_M1);
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = RX_START;
          par_bad_d = 1'b0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_full) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_full) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, sync2_q};
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_full) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    data             = shift_q;
    byte_valid       = 1'b0;
    frame_err_pulse  = 1'b0;
    parity_err_pulse = 1'b0;
    unique case (state_q)
`ifdef UART_RX_PARITY_EN
      RX_PARITY: parity_err_pulse = cnt_full & (^{shift_q, sync2_q});
`endif
      RX_STOP: begin
        if (cnt_full) begin
          frame_err_pulse = ~sync2_q;
          byte_valid      = sync2_q & ~par_bad_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmio_uart_rx.sv
// MMIO UART receiver: 256-byte ring buffer (64 x 32-bit words), queue pointers,
// sticky W1C status flags. UART_RX_PARITY_EN enables 8E1 framing and STATUS bit 2.
module mmio_uart_rx
  import mmio_uart_rx_pkg::*;
#(
  parameter int unsigned FMAX_MHz = 27,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(FMAX_MHz, BAUD);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, rx_parity_err;
  logic [31:0] ring_q [64];
  logic [7:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  flags_q, flags_d, flag_set, flag_clr;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write, full, enq;
  logic        unused_wdata;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk             (clk),
    .reset           (reset),
    .rx_in           (uart_rx),
    .data            (rx_data),
    .byte_valid      (rx_valid),
    .frame_err_pulse (rx_frame_err),
    .parity_err_pulse(rx_parity_err)
  );

  assign output_cmd_ready   = 1'b1;
  assign output_rdata_valid = 1'b1;
  assign output_rdata       = rdata_q;
  assign unused_wdata       = ^input_wdata[31:8];

  // Full check uses the pre-write head; set wins over a same-cycle W1C.
  always_comb begin
    is_write = input_cmd_start & input_cmd_write;
    full     = ((tail_q + 8'd1) == head_q);
    enq      = rx_valid & ~full;
    head_d   = (is_write && input_addr == UART_RX_QUEUE_HEAD_OFFSET) ? input_wdata[7:0] : head_q;
    tail_d   = enq ? tail_q + 8'd1 : tail_q;
    flag_clr = (is_write && input_addr == UART_RX_STATUS_OFFSET) ? input_wdata[2:0] : '0;
    flag_set = '0;
    flag_set[STATUS_OVERFLOW_BIT]   = rx_valid & full;
    flag_set[STATUS_FRAME_ERR_BIT]  = rx_frame_err;
    flag_set[STATUS_PARITY_ERR_BIT] = rx_parity_err;
    flags_d  = (flags_q & ~flag_clr) | flag_set;
  end

  always_comb begin
    rdata_d = '0;
    if (input_addr[31:8] == '0)
      rdata_d = ring_q[input_addr[7:2]];
    else if (input_addr == UART_RX_QUEUE_HEAD_OFFSET)
      rdata_d = {24'b0, head_q};
    else if (input_addr == UART_RX_QUEUE_TAIL_OFFSET)
      rdata_d = {24'b0, tail_q};
    else if (input_addr == UART_RX_STATUS_OFFSET)
      rdata_d = {29'b0, flags_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      flags_q <= '0;
      rdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      flags_q <= flags_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      ring_q[tail_q[7:2]][{tail_q[1:0], 3'b000} +: 8] <= rx_data;
  end

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Directed bench for mmio_uart_rx at CLKS_PER_BIT = 10 (FMAX_MHz=1, BAUD=100000).
module tb_mmio_uart_rx;
  import mmio_uart_rx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        input_cmd_start = 1'b0;
  logic        input_cmd_write = 1'b0;
  logic        output_cmd_ready;
  logic [31:0] input_addr = '0;
  logic [31:0] output_rdata;
  logic        output_rdata_valid;
  logic [31:0] input_wdata = '0;

  int checks = 0;
  int failures = 0;

  mmio_uart_rx #(
    .FMAX_MHz(1),
    .BAUD    (100000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .uart_rx           (uart_rx),
    .input_cmd_start   (input_cmd_start),
    .input_cmd_write   (input_cmd_write),
    .output_cmd_ready  (output_cmd_ready),
    .input_addr        (input_addr),
    .output_rdata      (output_rdata),
    .output_rdata_valid(output_rdata_valid),
    .input_wdata       (input_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    input_addr = a;
    @(posedge clk);
    #1;
    d = output_rdata;
    chk(tag, d & mask, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    input_addr      = a;
    input_wdata     = d;
    input_cmd_start = 1'b1;
    input_cmd_write = 1'b1;
    @(negedge clk);
    input_cmd_start = 1'b0;
    input_cmd_write = 1'b0;
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (10) @(negedge clk);
  endtask

  // One frame (correct even parity when parity is enabled), then one idle bit.
  task automatic send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^b);
`endif
    bit_time(stop_bit);
    bit_time(1'b1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic par);
    @(negedge clk);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(par);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask
`endif

  localparam logic [31:0] HEAD = UART_RX_QUEUE_HEAD_OFFSET;
  localparam logic [31:0] TAIL = UART_RX_QUEUE_TAIL_OFFSET;
  localparam logic [31:0] STAT = UART_RX_STATUS_OFFSET;
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rdata_in_reset", output_rdata, 32'h0);
    chk("cmd_ready", {31'b0, output_cmd_ready}, 32'h1);
    chk("rdata_valid", {31'b0, output_rdata_valid}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("head_reset", HEAD, ALL, 32'h0);
    rd_chk("tail_reset", TAIL, ALL, 32'h0);
    rd_chk("status_reset", STAT, ALL, 32'h0);

    // Two bytes into lanes 0 and 1 of word 0
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    rd_chk("tail_after_2", TAIL, ALL, 32'h2);
    rd_chk("word0_lo16", 32'h0, 32'h0000_FFFF, 32'h0000_4241);
    rd_chk("status_after_2", STAT, ALL, 32'h0);

    // Fill to 255 bytes with head=0; byte at offset p carries value p
    for (int p = 2; p < 255; p++) send(8'(p), 1'b1);
    rd_chk("tail_full", TAIL, ALL, 32'hFF);
    rd_chk("word16", 32'h40, ALL, 32'h4342_4140);
    rd_chk("word63_lo24", 32'hFC, 32'h00FF_FFFF, 32'h00FE_FDFC);
    rd_chk("status_at_full", STAT, ALL, 32'h0);
    send(8'hEE, 1'b1);
    rd_chk("tail_after_drop", TAIL, ALL, 32'hFF);
    rd_chk("status_overflow", STAT, ALL, 32'h1);
    wr(STAT, 32'h1);
    rd_chk("status_w1c_ovf", STAT, ALL, 32'h0);

    // Empty the queue by a head write, then wrap the tail through 0xFF
    wr(HEAD, 32'hFF);
    rd_chk("head_written", HEAD, ALL, 32'hFF);
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    send(8'hA3, 1'b1);
    rd_chk("tail_wrapped", TAIL, ALL, 32'h2);
    rd_chk("word63_wrap", 32'hFC, ALL, 32'hA1FE_FDFC);
    rd_chk("word0_wrap", 32'h0, 32'h0000_FFFF, 32'h0000_A3A2);
    rd_chk("status_wrap", STAT, ALL, 32'h0);

    // Framing error
    send(8'h5A, 1'b0);
    rd_chk("tail_frame_err", TAIL, ALL, 32'h2);
    rd_chk("status_frame_err", STAT, ALL, 32'h2);
    wr(STAT, 32'h2);
    rd_chk("status_w1c_frame", STAT, ALL, 32'h0);

    // 3-cycle glitch on the idle line
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("tail_glitch", TAIL, ALL, 32'h2);
    rd_chk("status_glitch", STAT, ALL, 32'h0);

    // Reset during data bit 4 of a 0x00 frame, line held low through and after
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (55) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    rd_chk("tail_post_reset", TAIL, ALL, 32'h0);
    rd_chk("head_post_reset", HEAD, ALL, 32'h0);
    repeat (120) @(negedge clk);
    rd_chk("tail_low_hold", TAIL, ALL, 32'h0);
    rd_chk("status_low_hold", STAT, ALL, 32'h0);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h55, 1'b1);
    rd_chk("tail_after_55", TAIL, ALL, 32'h1);
    rd_chk("word0_after_55", 32'h0, 32'h0000_FFFF, 32'h0000_A355);
    rd_chk("status_after_55", STAT, ALL, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_par(8'h03, 1'b1);
    rd_chk("tail_bad_par", TAIL, ALL, 32'h1);
    rd_chk("status_bad_par", STAT, ALL, 32'h4);
    wr(STAT, 32'h4);
    rd_chk("status_w1c_par", STAT, ALL, 32'h0);
    send_par(8'h03, 1'b0);
    rd_chk("tail_good_par", TAIL, ALL, 32'h2);
    rd_chk("word0_good_par", 32'h0, 32'h0000_FF00, 32'h0000_0300);
    rd_chk("status_good_par", STAT, ALL, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
